// File: rtl/pico_pkg.sv
// Shared opcodes, ALU function codes and sequencer states for the picoMIPS decoder.
// Widths are fixed here; the top casts them to its parametrised field widths.
package pico_pkg;
  localparam int OP_ADD  = 'h0;
  localparam int OP_ADDI = 'h1;
  localparam int OP_SUB  = 'h2;
  localparam int OP_MUL  = 'h3;
  localparam int OP_HOLD = 'h4;
  localparam int OP_BEQ  = 'h5;
  localparam int OP_BNE  = 'h6;
  localparam int OP_NOP  = 'hF;

  localparam int RADD = 0;
  localparam int RSUB = 1;
  localparam int RMUL = 2;

  typedef enum logic {RUN, MULWAIT} state_t;
endpackage

// File: rtl/pico_sync.sv
// Multi-flop synchroniser for the asynchronous HOLD switch; STAGES edges of latency.
module pico_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nReset,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) r_chain <= '0;
    else         r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/pico_seq_decoder.sv
// Sequencing picoMIPS decoder: combinational control decode plus MUL stall counter and HOLD handshake.
// Optional zero-flag branches are enabled by defining PICO_BRANCH_EN.
module pico_seq_decoder
  import pico_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALUF_W      = 4,
  parameter int MUL_CYCLES  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                swhold,
  input  logic                inflag,
  input  logic                zflag,
  output logic                PCincr,
  output logic                PCload,
  output logic [ALUF_W-1:0]   ALUfunc,
  output logic                imm,
  output logic                ipc,
  output logic                w,
  output logic                holdflag,
  output logic                busy
);
  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [OPCODE_W-1:0] L_ADD  = OPCODE_W'(OP_ADD);
  localparam logic [OPCODE_W-1:0] L_ADDI = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] L_SUB  = OPCODE_W'(OP_SUB);
  localparam logic [OPCODE_W-1:0] L_MUL  = OPCODE_W'(OP_MUL);
  localparam logic [OPCODE_W-1:0] L_HOLD = OPCODE_W'(OP_HOLD);
  localparam logic [ALUF_W-1:0]   L_RADD = ALUF_W'(RADD);
  localparam logic [ALUF_W-1:0]   L_RSUB = ALUF_W'(RSUB);
  localparam logic [ALUF_W-1:0]   L_RMUL = ALUF_W'(RMUL);

  state_t            r_state;
  logic [CNT_W-1:0]  r_mul_cnt;
  logic              r_holdflag;
  logic              w_sw_s;
  logic              w_pcincr, w_imm, w_ipc, w_we, w_busy;
  logic [ALUF_W-1:0] w_alu;
`ifdef PICO_BRANCH_EN
  localparam logic [OPCODE_W-1:0] L_BEQ = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] L_BNE = OPCODE_W'(OP_BNE);
  logic              w_pcload;
`endif

  pico_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .nReset (nReset),
    .i_d    (swhold),
    .o_q    (w_sw_s)
  );

  always_comb begin
    w_pcincr = 1'b1;
    w_alu    = L_RADD;
    w_imm    = 1'b0;
    w_ipc    = 1'b0;
    w_we     = 1'b0;
    w_busy   = 1'b0;
`ifdef PICO_BRANCH_EN
    w_pcload = 1'b0;
`endif
    if (r_state == MULWAIT) begin
      // opcode is ignored while stalled: the PC still points at the MUL
      w_alu = L_RMUL;
      if (r_mul_cnt == CNT_LAST) begin
        w_we = 1'b1;
      end else begin
        w_pcincr = 1'b0;
        w_busy   = 1'b1;
      end
    end else begin
      case (opcode)
        L_ADD:  begin w_we = 1'b1; w_ipc = inflag; end
        L_ADDI: begin w_we = 1'b1; w_imm = 1'b1; end
        L_SUB:  begin w_we = 1'b1; w_ipc = inflag; w_alu = L_RSUB; end
        L_MUL: begin
          w_alu = L_RMUL;
          if (MUL_CYCLES == 1) begin
            w_we = 1'b1;
          end else begin
            w_pcincr = 1'b0;
            w_busy   = 1'b1;
          end
        end
        L_HOLD: w_pcincr = (w_sw_s != r_holdflag);
`ifdef PICO_BRANCH_EN
        L_BEQ:  begin w_imm = 1'b1; w_pcload = zflag;  w_pcincr = !zflag; end
        L_BNE:  begin w_imm = 1'b1; w_pcload = !zflag; w_pcincr = zflag;  end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= RUN;
      r_mul_cnt  <= '0;
      r_holdflag <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (opcode == L_MUL && MUL_CYCLES > 1) begin
            r_state   <= MULWAIT;
            r_mul_cnt <= CNT_W'(1);
          end else if (opcode == L_HOLD) begin
            r_holdflag <= w_sw_s;
          end
        end
        MULWAIT: begin
          if (r_mul_cnt == CNT_LAST) begin
            r_state   <= RUN;
            r_mul_cnt <= '0;
          end else begin
            r_mul_cnt <= r_mul_cnt + CNT_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign PCincr   = nReset & w_pcincr;
  assign ALUfunc  = nReset ? w_alu : L_RADD;
  assign imm      = nReset & w_imm;
  assign ipc      = nReset & w_ipc;
  assign w        = nReset & w_we;
  assign busy     = nReset & w_busy;
  assign holdflag = r_holdflag;
`ifdef PICO_BRANCH_EN
  assign PCload   = nReset & w_pcload;
`else
  // zflag has no consumer without branches; PCload stays low
  assign PCload   = zflag & 1'b0;
`endif
endmodule
